dmem_ws: RTL and testbench
==========================

Name: dmem_ws

Overview:
Parametrised data memory with a wait-state request/ready handshake. It replaces the fixed single-cycle data memory on the pipelined ARM core's M-stage port. It adds configurable depth and width, byte-lane write enables, a programmable access latency and an address-range error flag. The core freezes its pipeline on `stall` until `ready` pulses, so the same core runs against slow or fast memory models.

Parameters:
- DATA_W, 32: data width in bits; must be a multiple of 8.
- ADDR_W, 32: byte-address width.
- DEPTH, 64: number of words; power of two, ≥2.
- WAIT, 2: extra wait cycles per access, 0..15.
- INIT_FILE, "": hex file loaded with $readmemh at elaboration when non-empty.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- req, input, 1: access request, level-sensitive.
- we, input, 1: 1 = write, 0 = read; sampled with req.
- a, input, ADDR_W: byte address; bits [1:0] ignored (word access).
- wd, input, DATA_W: write data.
- be, input, DATA_W/8: byte-lane enables for writes; ignored on reads.
- rd, output, DATA_W: read data, valid while ready=1.
- ready, output, 1: one-cycle completion pulse.
- err, output, 1: address out of range; valid while ready=1.
- stall, output, 1: combinational, req & ~ready; drives core pipeline freeze.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, rd=0, ready=0, err=0, wait counter=0.
  - Memory contents are not cleared.
  - Reset asserted mid-transaction aborts it: no array write, no ready pulse.
- Index and range check:
  - idx = a[log2(DEPTH)+1:2].
  - Out of range when any a[ADDR_W-1:log2(DEPTH)+2] != 0.
- States IDLE, WAIT, RESP:
  - IDLE, req=1: latch a, we, wd, be and the range check. Go to WAIT if WAIT>0, else to RESP. Load counter with WAIT-1.
  - WAIT: decrement counter each cycle; at 0 go to RESP.
  - RESP: ready=1 for exactly one cycle, then IDLE.
- Latency: ready rises WAIT+1 cycles after the accepting edge. Back-to-back accesses with req held high occur every WAIT+2 cycles (one IDLE cycle between).
- Inputs while not in IDLE: ignored. Only the latched copies are used.
- Write: on the edge entering RESP, for each lane i with latched be[i]=1, byte i of mem[idx] <= wd byte i.
  - be all zero: no change, ready still pulses.
  - Out of range: no write, err=1.
- Read: on the edge entering RESP, rd <= mem[idx], or 0 if out of range (err=1). rd holds its value after ready drops until the next read completes. Writes leave rd unchanged.
- err is 0 on any in-range completion and 0 outside RESP.
- req dropped while in WAIT: the transaction still completes and ready pulses (no cancel).
- stall=1 from the first cycle req=1 through the cycle before ready. stall=0 in the ready cycle, so the core advances exactly on ready.

Test Plan:
- Reset then idle: reset=0 for 3 cycles with req=0 -> rd=0, ready=0, err=0, stall=0. After release, still idle.
- Full write then read, WAIT=2: write a=0x10, wd=0xDEADBEEF, be=0xF. Then read a=0x10 -> each ready pulse arrives 3 cycles after accept, stall high 3 cycles per access, rd=0xDEADBEEF, err=0.
- Byte lanes: mem[4]=0x11223344, write a=0x10, wd=0xAABBCCDD, be=0b0101 -> read returns 0x11BB33DD.
- Out of range, DEPTH=64: write to a=0x100 -> err=1 on ready, no array change. Read of a=0x100 -> rd=0, err=1.
- WAIT=0 and back-to-back: req held high for 4 reads of a=0,4,8,12 (address changed on each ready) -> ready pulses every 2 cycles, data in order.
- Reset mid-access: assert reset during WAIT of a write to a=0x20 -> no ready pulse, mem[8] unchanged. State returns to IDLE asynchronously.

Source files
------------

// File: rtl/dmem_ws.sv
// ---------------------------------------------------------------------------
// dmem_ws : word-addressed data memory with a wait-state request/ready
//           handshake, byte-lane write enables and an address-range error.
//
// Each access goes IDLE -> (WAIT x WAIT cycles) -> RESP. The one-cycle
// RESP state produces the ready pulse. The core holds its pipeline while
// stall is high and advances on the cycle where ready is high.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active low
//   req    in   access request (level); sampled only in IDLE
//   we     in   1 = write, 0 = read
//   a      in   byte address; a[1:0] ignored
//   wd     in   write data
//   be     in   byte-lane write enables (ignored on reads)
//   rd     out  read data; valid with ready, held until the next read completes
//   ready  out  one-cycle completion pulse
//   err    out  address out of range; valid with ready
//   stall  out  req & ~ready (combinational)
//
// States
//   state  | meaning
//   S_IDLE | waiting for req; samples the access
//   S_WAIT | counting down the programmed wait cycles
//   S_RESP | ready pulse; rd/err present
// ---------------------------------------------------------------------------
module dmem_ws #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 32,
    parameter int    DEPTH     = 64,
    parameter int    WAIT      = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   a,
    input  logic [DATA_W-1:0]   wd,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rd,
    output logic                ready,
    output logic                err,
    output logic                stall
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [IDX_W-1:0]    idx_q,  idx_d;
    logic                we_q,   we_d;
    logic [DATA_W-1:0]   wd_q,   wd_d;
    logic [BE_W-1:0]     be_q,   be_d;
    logic                oor_q,  oor_d;
    logic [DATA_W-1:0]   rd_q;
    logic                ready_q;
    logic                err_q;
    logic                enter_resp;
    logic                unused_a;

    logic [DATA_W-1:0]   mem [DEPTH];

    assign unused_a = ^a[1:0];

    // Access fields as used on the edge entering RESP. In IDLE they come
    // straight from the ports so that WAIT=0 can complete on the accepting
    // edge; afterwards only the latched copies matter.
    always_comb begin
        idx_d = idx_q;
        we_d  = we_q;
        wd_d  = wd_q;
        be_d  = be_q;
        oor_d = oor_q;
        if (state_q == S_IDLE) begin
            idx_d = a[IDX_W+1:2];
            we_d  = we;
            wd_d  = wd;
            be_d  = be;
            oor_d = |(a >> (IDX_W + 2));
        end
    end

    assign enter_resp = ((state_q == S_IDLE) && req && (WAIT == 0)) ||
                        ((state_q == S_WAIT) && (cnt_q == 4'd0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            be_q    <= '0;
            oor_q   <= 1'b0;
            rd_q    <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            oor_q   <= oor_d;
            ready_q <= 1'b0;
            err_q   <= 1'b0;

            if (enter_resp) begin
                ready_q <= 1'b1;
                err_q   <= oor_d;
                if (!we_d) rd_q <= oor_d ? '0 : mem[idx_d];
            end

            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        cnt_q   <= CNT_INIT;
                        state_q <= (WAIT == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Array has no reset. Gating with reset keeps an access that is being
    // aborted from landing in the array.
    always_ff @(posedge clk) begin
        if (enter_resp && reset && we_d && !oor_d) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_d[i]) mem[idx_d][8*i +: 8] <= wd_d[8*i +: 8];
            end
        end
    end

    assign rd    = rd_q;
    assign ready = ready_q;
    assign err   = err_q;
    assign stall = req & ~ready_q;

endmodule

// File: tb/tb_dmem_ws.sv
// Scoreboard bench for dmem_ws. Two instances: index 0 with WAIT=2,
// index 1 with WAIT=0, both DEPTH=64. Drivers push the expected response
// into a queue; the monitor pops on every ready pulse.
module tb_dmem_ws;

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
    } op_t;

    typedef struct {
        int          k;
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req_s = '0;
    logic [1:0]       we_s = '0;
    logic [1:0][31:0] a_s = '0;
    logic [1:0][31:0] wd_s = '0;
    logic [1:0][3:0]  be_s = '0;
    logic [1:0][31:0] rd_s;
    logic [1:0]       ready_s;
    logic [1:0]       err_s;
    logic [1:0]       stall_s;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          stall_cnt [2];
    logic [31:0] mdl [2][64];
    logic [31:0] last_rd [2];
    exp_t        sbq [$];
    op_t         ops [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT(2), .INIT_FILE("")) u_dut_w2 (
        .clk(clk), .reset(rst_n), .req(req_s[0]), .we(we_s[0]), .a(a_s[0]),
        .wd(wd_s[0]), .be(be_s[0]), .rd(rd_s[0]), .ready(ready_s[0]),
        .err(err_s[0]), .stall(stall_s[0])
    );

    dmem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(64), .WAIT(0), .INIT_FILE("")) u_dut_w0 (
        .clk(clk), .reset(rst_n), .req(req_s[1]), .we(we_s[1]), .a(a_s[1]),
        .wd(wd_s[1]), .be(be_s[1]), .rd(rd_s[1]), .ready(ready_s[1]),
        .err(err_s[1]), .stall(stall_s[1])
    );

    function automatic int wt(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add_op(input bit we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
        op_t o;
        o.we = we; o.a = a; o.wd = wd; o.be = be;
        ops.push_back(o);
    endtask

    function automatic op_t rnd_op();
        op_t o;
        o.we = bit'($urandom_range(0, 1));
        o.wd = $urandom;
        o.be = 4'($urandom);
        o.a  = {24'h0, 6'($urandom), 2'($urandom)};
        if ($urandom_range(0, 5) == 0) o.a[8 + $urandom_range(0, 23)] = 1'b1;
        return o;
    endfunction

    // Reference: 64 words, word index = byte address / 4, anything at or
    // above byte 256 is out of range.
    task automatic push_exp(input int k, input op_t o, input int c);
        exp_t        e;
        int          w;
        bit          oor;
        logic [31:0] m;
        oor = (o.a >= 32'h100);
        w   = int'((o.a >> 2) % 64);
        m   = '0;
        for (int i = 0; i < 4; i++) if (o.be[i]) m[8*i +: 8] = 8'hFF;
        e.k = k; e.cyc = c; e.err = oor;
        if (o.we) begin
            if (!oor) mdl[k][w] = (mdl[k][w] & ~m) | (o.wd & m);
            e.rd = last_rd[k];
        end else begin
            e.rd = oor ? 32'h0 : mdl[k][w];
            last_rd[k] = e.rd;
        end
        sbq.push_back(e);
    endtask

    task automatic present(input int k, input op_t o);
        req_s[k] = 1'b1;
        we_s[k]  = o.we;
        a_s[k]   = o.a;
        wd_s[k]  = o.wd;
        be_s[k]  = o.be;
    endtask

    task automatic wait_ready(input int k, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready_s[k]) begin
                ok = 1'b1;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL ready_timeout dut=%0d: got no ready want ready within 40 cycles", k);
    endtask

    // Runs everything in ops on instance k. With hold=1 req stays high and
    // the next access is put on the bus in the ready cycle (back-to-back).
    task automatic run_burst(input int k, input bit hold);
        bit  from_idle;
        bit  ok;
        op_t o;
        from_idle = 1'b1;
        while (ops.size() > 0) begin
            o = ops.pop_front();
            present(k, o);
            // From idle: ready WAIT+1 cycles later. Presented during ready:
            // one extra IDLE cycle first.
            push_exp(k, o, cyc + wt(k) + (from_idle ? 1 : 2));
            wait_ready(k, ok);
            if (ok && hold && ops.size() > 0) begin
                from_idle = 1'b0;
            end else begin
                req_s[k]  = 1'b0;
                from_idle = 1'b1;
                @(negedge clk);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                stall_cnt[k] = 0;
            end else begin
                if (stall_s[k]) stall_cnt[k]++;
                if (ready_s[k]) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_ready dut=%0d: got ready=1 want no pending access", k);
                    end else begin
                        e = sbq.pop_front();
                        chk("dut_id", k, e.k);
                        chk("rd", rd_s[k], e.rd);
                        chk("err", {31'h0, err_s[k]}, {31'h0, e.err});
                        chk("ready_cycle", cyc, e.cyc);
                        chk("stall_cycles", stall_cnt[k], wt(k) + 1);
                    end
                    stall_cnt[k] = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        stall_cnt[0] = 0; stall_cnt[1] = 0;
        last_rd[0] = '0;  last_rd[1] = '0;

        // Reset with req low for 3 cycles.
        repeat (3) @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_rd", rd_s[k], 32'h0);
            chk("rst_ready", {31'h0, ready_s[k]}, 32'h0);
            chk("rst_err", {31'h0, err_s[k]}, 32'h0);
            chk("rst_stall", {31'h0, stall_s[k]}, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("idle_ready", {31'h0, ready_s[k]}, 32'h0);
            chk("idle_stall", {31'h0, stall_s[k]}, 32'h0);
        end
        @(negedge clk);

        // Fill both arrays so every later read has a known value.
        for (int k = 0; k < 2; k++) begin
            for (int w = 0; w < 64; w++) add_op(1'b1, 32'(w * 4), $urandom, 4'hF);
            run_burst(k, 1'b1);
        end

        // WAIT=2: full write/read, byte lanes, out of range.
        add_op(1'b1, 32'h10,  32'hDEADBEEF, 4'hF);
        add_op(1'b0, 32'h10,  32'h0,        4'h0);
        add_op(1'b1, 32'h10,  32'h11223344, 4'hF);
        add_op(1'b1, 32'h10,  32'hAABBCCDD, 4'b0101);
        add_op(1'b0, 32'h10,  32'h0,        4'h0);
        add_op(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF);
        add_op(1'b0, 32'h100, 32'h0,        4'h0);
        add_op(1'b0, 32'h0,   32'h0,        4'h0);
        add_op(1'b1, 32'h24,  32'h12345678, 4'h0);
        add_op(1'b0, 32'h24,  32'h0,        4'h0);
        run_burst(0, 1'b0);

        // WAIT=0: back-to-back reads with req held high.
        for (int w = 0; w < 4; w++) add_op(1'b0, 32'(w * 4), 32'h0, 4'h0);
        run_burst(1, 1'b1);

        // Random traffic on both instances.
        for (int b = 0; b < 6; b++) begin
            for (int i = 0; i < 20; i++) ops.push_back(rnd_op());
            run_burst(b % 2, bit'($urandom_range(0, 1)));
        end

        // Reset in the middle of a write on the WAIT=2 instance.
        add_op(1'b1, 32'h20, 32'h5A5A0001, 4'hF);
        add_op(1'b0, 32'h20, 32'h0,        4'h0);
        run_burst(0, 1'b0);
        o.we = 1'b1; o.a = 32'h20; o.wd = 32'hA5A5FFFE; o.be = 4'hF;
        present(0, o);
        repeat (2) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_rd_cleared", rd_s[0], 32'h0);
        chk("abort_ready", {31'h0, ready_s[0]}, 32'h0);
        chk("abort_stall", {31'h0, stall_s[0]}, {31'h0, req_s[0]});
        req_s[0] = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        add_op(1'b0, 32'h20, 32'h0, 4'h0);
        run_burst(0, 1'b0);

        repeat (4) @(negedge clk);
        #3;
        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
